// File: rtl/dmem_access_pkg.sv
// Shared encodings for the data-memory access controller: op codes and FSM states.
package dmem_access_pkg;

   localparam int unsigned OP_W = 2;

   localparam logic [OP_W-1:0] OP_LW  = 2'b00;
   localparam logic [OP_W-1:0] OP_LB  = 2'b01;
   localparam logic [OP_W-1:0] OP_SW  = 2'b10;
   localparam logic [OP_W-1:0] OP_ILL = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      RESP   = 2'd3
   } state_t;

endpackage

// File: rtl/dmem_access_ctrl.sv
// Clocked initiator for the byte-addressable data memory: one request at a time,
// address/data/LB set up a cycle ahead of a single-cycle level strobe.
// Optional feature: define DMEM_ACCESS_BOUNDS_CHECK_EN to reject accesses that run
// past the end of the memory (no strobe, error response).
module dmem_access_ctrl
   import dmem_access_pkg::*;
#(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned MEM_BYTES = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic              mem_lb,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

`ifdef DMEM_ACCESS_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(MEM_BYTES - 2);
   localparam logic [ADDR_W-1:0] LAST_BYTE_ADDR = ADDR_W'(MEM_BYTES - 1);

   state_t            r_state;
   logic [OP_W-1:0]   r_op;
   logic              w_oob;
   logic              w_err;
   logic [DATA_W-1:0] w_load_data;

   // Out-of-bounds detection on the captured request; a word needs two in-range bytes.
   assign w_oob = BOUNDS_EN &&
                  ((r_op == OP_LB) ? (mem_address > LAST_BYTE_ADDR)
                                   : (mem_address > LAST_WORD_ADDR));
   assign w_err = (r_op == OP_ILL) || w_oob;

   // Shape the memory read data into the response word for the captured op.
   always_comb begin
      w_load_data = '0;
      case (r_op)
         OP_LW:   w_load_data = mem_rdata;
         OP_LB:   w_load_data = {{(DATA_W - 8){1'b0}}, mem_rdata[7:0]};
         default: w_load_data = '0;
      endcase
   end

   // Access sequencer: IDLE -> SETUP -> STROBE -> RESP, with SETUP -> RESP on error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_op        <= OP_LW;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         resp_err    <= 1'b0;
         mem_address <= '0;
         mem_wr      <= 1'b0;
         mem_rd      <= 1'b0;
         mem_lb      <= 1'b0;
         mem_wdata   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  r_op        <= req_op;
                  mem_address <= req_addr;
                  mem_wdata   <= req_wdata;
                  mem_lb      <= (req_op == OP_LB);
                  req_ready   <= 1'b0;
                  r_state     <= SETUP;
               end
            end
            SETUP: begin
               if (w_err) begin
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
                  r_state    <= RESP;
               end else begin
                  mem_rd  <= (r_op != OP_SW);
                  mem_wr  <= (r_op == OP_SW);
                  r_state <= STROBE;
               end
            end
            STROBE: begin
               mem_rd     <= 1'b0;
               mem_wr     <= 1'b0;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= w_load_data;
               r_state    <= RESP;
            end
            RESP: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
               req_ready  <= 1'b1;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
